// File: rtl/io_ctrl_pkg.sv
// rtl/io_ctrl_pkg.sv - shared types and constants for the I/O port controller
package io_ctrl_pkg;

  localparam int PORT_W = 16;
  localparam logic [3:0] ACK_TAG_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ANNOUNCE = 2'd1,
    WAIT_ACK = 2'd2
  } irq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a full FIFO still accepts a push when a pop lands on the same edge
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so downstream ports idle at a known value.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_port_controller.sv
// rtl/io_port_controller.sv - RX/TX buffering, output-port write detection and one-shot interrupt announce
module io_port_controller
  import io_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [3:0] ACK_TAG = ACK_TAG_DEFAULT,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [PORT_W-1:0] i_output_port,
  output logic [PORT_W-1:0] o_input_port,
  output logic              o_interrupt,
  input  logic              i_rx_valid,
  input  logic [PORT_W-1:0] i_rx_data,
  output logic              o_rx_ready,
  output logic              o_tx_valid,
  output logic [PORT_W-1:0] o_tx_data,
  input  logic              i_tx_ready,
  output logic [CW-1:0]     o_rx_count,
  output logic              o_tx_overflow
);

  irq_state_t        state;
  irq_state_t        state_next;
  logic [PORT_W-1:0] prev_port;
  logic              port_event;
  logic              ack;
  logic              data_write;
  logic              rx_push;
  logic              rx_pop;
  logic              rx_full;
  logic              rx_empty;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic [CW-1:0]     tx_count;

  // A CPU write is only visible as a change of the port value.
  assign port_event = (i_output_port != prev_port);
  assign ack        = port_event && (i_output_port[PORT_W-1 -: 4] == ACK_TAG);
  assign data_write = port_event && !ack;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) prev_port <= '0;
    else         prev_port <= i_output_port;
  end

  assign o_rx_ready = !rx_full;
  assign rx_push    = i_rx_valid && o_rx_ready;
  assign rx_pop     = ack && (state != IDLE);
  assign o_tx_valid = (tx_count != '0);
  assign tx_pop     = i_tx_ready && !tx_empty;

  sync_fifo #(.WIDTH(PORT_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (rx_push),
    .din   (i_rx_data),
    .pop   (rx_pop),
    .head  (o_input_port),
    .full  (rx_full),
    .empty (rx_empty),
    .count (o_rx_count)
  );

  sync_fifo #(.WIDTH(PORT_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (data_write),
    .din   (i_output_port),
    .pop   (tx_pop),
    .head  (o_tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                               o_tx_overflow <= 1'b0;
    else if (data_write && tx_full && !tx_pop) o_tx_overflow <= 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // An ack only counts once the head has been announced.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (!rx_empty) state_next = ANNOUNCE;
      ANNOUNCE: state_next = ack ? IDLE : WAIT_ACK;
      WAIT_ACK: if (ack) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    o_interrupt = (state == ANNOUNCE);
  end

endmodule

// File: tb/tb_io_port_controller.sv
// tb/tb_io_port_controller.sv - randomized scoreboard bench for io_port_controller
module tb_io_port_controller;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_output_port = 16'h0000;
  logic [15:0] o_input_port;
  logic        o_interrupt;
  logic        i_rx_valid = 1'b0;
  logic [15:0] i_rx_data = 16'h0000;
  logic        o_rx_ready;
  logic        o_tx_valid;
  logic [15:0] o_tx_data;
  logic        i_tx_ready = 1'b0;
  logic [2:0]  o_rx_count;
  logic        o_tx_overflow;

  always #5 i_clk = ~i_clk;

  io_port_controller #(.DEPTH(DEPTH), .ACK_TAG(4'hF)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_output_port (i_output_port),
    .o_input_port  (o_input_port),
    .o_interrupt   (o_interrupt),
    .i_rx_valid    (i_rx_valid),
    .i_rx_data     (i_rx_data),
    .o_rx_ready    (o_rx_ready),
    .o_tx_valid    (o_tx_valid),
    .o_tx_data     (o_tx_data),
    .i_tx_ready    (i_tx_ready),
    .o_rx_count    (o_rx_count),
    .o_tx_overflow (o_tx_overflow)
  );

  typedef struct {
    int          cyc;
    logic [15:0] word;
  } irq_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: RX contents, TX occupancy, sticky overflow, and whether a head is announced.
  logic [15:0] m_rx[$];
  int          m_tx_cnt;
  bit          m_ovf;
  bit          m_busy;
  logic [15:0] m_prev;
  logic [15:0] exp_tx[$];
  irq_t        exp_irq[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rx.delete();
    m_tx_cnt = 0;
    m_ovf    = 0;
    m_busy   = 0;
    m_prev   = 16'h0000;
    exp_tx.delete();
    exp_irq.delete();
  endtask

  task automatic model_edge();
    bit ev, ack, acked, rx_ne, pulse, tx_pop, tx_full, rx_push;
    ev      = (i_output_port != m_prev);
    m_prev  = i_output_port;
    ack     = ev && (i_output_port[15:12] == 4'hF);
    rx_ne   = (m_rx.size() != 0);
    acked   = ack && m_busy;
    pulse   = !m_busy && rx_ne;
    rx_push = i_rx_valid && (m_rx.size() < DEPTH);
    if (acked) void'(m_rx.pop_front());
    if (rx_push) m_rx.push_back(i_rx_data);
    m_busy = acked ? 1'b0 : (m_busy || rx_ne);
    if (pulse) exp_irq.push_back('{cyc, m_rx[0]});
    tx_full = (m_tx_cnt == DEPTH);
    tx_pop  = (m_tx_cnt > 0) && i_tx_ready;
    if (tx_pop) m_tx_cnt--;
    if (ev && !ack) begin
      if (!tx_full || tx_pop) begin
        exp_tx.push_back(i_output_port);
        m_tx_cnt++;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic step(logic rv, logic [15:0] rd, logic [15:0] port, logic tr);
    @(posedge i_clk);
    cyc++;
    if (!i_reset) model_edge();
    #1;
    i_rx_valid    = rv;
    i_rx_data     = rd;
    i_output_port = port;
    i_tx_ready    = tr;
  endtask

  task automatic idle(int n, logic tr);
    repeat (n) step(1'b0, 16'h0000, i_output_port, tr);
  endtask

  task automatic do_reset(int n);
    @(posedge i_clk);
    cyc++;
    if (!i_reset) model_edge();
    #1;
    i_reset = 1'b1;
    model_reset();
    repeat (n) begin
      @(posedge i_clk);
      cyc++;
    end
    #1;
    i_reset = 1'b0;
  endtask

  always @(negedge i_clk) begin
    logic [15:0] head_exp;
    bit          irq_now;
    head_exp = (m_rx.size() != 0) ? m_rx[0] : 16'h0000;
    check("input_port", 32'(o_input_port), 32'(head_exp));
    check("rx_count", 32'(o_rx_count), 32'(m_rx.size()));
    check("rx_ready", 32'(o_rx_ready), 32'(m_rx.size() < DEPTH));
    check("tx_valid", 32'(o_tx_valid), 32'(m_tx_cnt != 0));
    check("tx_overflow", 32'(o_tx_overflow), 32'(m_ovf));
    if (i_reset) check("tx_data_reset", 32'(o_tx_data), 32'h0);
    irq_now = (exp_irq.size() != 0) && (exp_irq[0].cyc == cyc);
    check("interrupt", 32'(o_interrupt), 32'(irq_now));
    if (irq_now) begin
      check("irq_head", 32'(o_input_port), 32'(exp_irq[0].word));
      void'(exp_irq.pop_front());
    end
    if (o_tx_valid && i_tx_ready) begin
      if (exp_tx.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected cyc=%0d got=%h want=none", cyc, o_tx_data);
      end else begin
        check("tx_data", 32'(o_tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  initial begin
    bit          slow;
    logic [15:0] port;
    int          r;
    model_reset();
    repeat (2) begin
      @(posedge i_clk);
      cyc++;
    end
    #1;
    i_reset = 1'b0;

    step(1'b1, 16'h1234, 16'h0000, 1'b0);
    idle(5, 1'b0);

    do_reset(1);
    step(1'b1, 16'hAAAA, 16'h0000, 1'b0);
    step(1'b1, 16'hBBBB, 16'h0000, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 16'h0000, 16'hF000, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 16'h0000, 16'hF001, 1'b0);
    idle(3, 1'b0);

    do_reset(1);
    step(1'b0, 16'h0000, 16'hF000, 1'b0);
    step(1'b1, 16'h0001, 16'hF000, 1'b0);
    idle(4, 1'b0);

    do_reset(1);
    step(1'b0, 16'h0000, 16'hF000, 1'b0);
    step(1'b0, 16'h0000, 16'h0005, 1'b0);
    step(1'b0, 16'h0000, 16'h0005, 1'b0);
    step(1'b0, 16'h0000, 16'h0006, 1'b0);
    idle(1, 1'b0);
    idle(3, 1'b1);

    do_reset(1);
    for (int i = 1; i <= 5; i++) step(1'b0, 16'h0000, 16'(i), 1'b0);
    idle(1, 1'b0);
    idle(5, 1'b1);

    do_reset(1);
    for (int i = 1; i <= 4; i++) step(1'b0, 16'h0000, 16'(16 + i), 1'b0);
    step(1'b0, 16'h0000, 16'h0015, 1'b1);
    idle(1, 1'b0);
    idle(6, 1'b1);

    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'hC000 + i), 16'h0015, 1'b0);
    step(1'b1, 16'hDEAD, 16'h0015, 1'b0);
    idle(3, 1'b0);
    do_reset(2);
    idle(5, 1'b0);

    slow = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 700 == 699) do_reset(2);
      if (i % 200 == 0) slow = ~slow;
      r    = $urandom_range(0, 9);
      port = i_output_port;
      if (r < 3)      port = {4'hF, 12'($urandom)};
      else if (r < 6) port = {4'($urandom_range(0, 14)), 12'($urandom)};
      step(1'($urandom_range(0, 1)), 16'($urandom), port,
           slow ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1)));
    end
    idle(2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_port_controller.md
# io_port_controller

Device-side I/O controller that sits on the far side of the CPU's port and interrupt pins. It buffers words arriving from an external producer, presents the head word on the CPU input port, and raises a one-cycle interrupt for each word. It also detects CPU output-port writes, which are either acknowledge commands (pop the announced RX word) or data forwarded to an external consumer through a TX FIFO.

## Interface
- DEPTH, 4: entries per FIFO; power of two, ≥2
- ACK_TAG, 4'hF: value of bits [15:12] that marks an output-port write as an acknowledge
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_output_port  in  16  driven by CPU o_output_port
- o_input_port  out  16  to CPU i_input_port
- o_interrupt  out  1  to CPU i_interrupt; one-cycle pulse
- i_rx_valid  in  1  external producer word valid
- i_rx_data  in  16  external producer word
- o_rx_ready  out  1  RX FIFO not full
- o_tx_valid  out  1  TX FIFO not empty
- o_tx_data  out  16  TX FIFO head
- i_tx_ready  in  1  external consumer accepts
- o_rx_count  out  $clog2(DEPTH)+1  RX occupancy
- o_tx_overflow  out  1  sticky: a TX word was dropped

## Operation
- Write event: prev_port register (reset 16'h0000) holds the last sampled i_output_port. Event = i_output_port != prev_port. prev_port updates every cycle.
- An event with new value [15:12]==ACK_TAG is an ack. Every other event is data and is pushed into the TX FIFO.
- Repeated identical writes produce no event. Software must alternate ack values (e.g. 16'hF000/16'hF001) between consecutive acks.
- RX push: i_rx_valid & o_rx_ready. No pass-through: o_rx_ready = !rx_full.
- o_input_port = RX head when non-empty, else 16'h0000.
- Interrupt FSM states:
  - IDLE: moves to ANNOUNCE when RX is non-empty.
  - ANNOUNCE: o_interrupt=1; moves to WAIT_ACK, or to IDLE if an ack arrives in this cycle.
  - WAIT_ACK: on ack, pop RX and move to IDLE.
- An ack in IDLE is ignored, whether RX is empty or not; only an announced head can be acked. Each ack pops exactly one word.
- After a pop with words remaining, the FSM announces the next head: IDLE→ANNOUNCE on the following edge.
- TX: pushing into a full TX FIFO drops the word and sets o_tx_overflow. Exception: if a pop (o_tx_valid & i_tx_ready) happens in the same cycle, the push is accepted.
- o_tx_overflow clears only on reset.
- Push and pop in the same cycle on either FIFO leave the count unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Counts are one bit wider, so full = count==DEPTH.

## Timing
- Reset values, applied asynchronously: FSM=IDLE; both FIFOs empty; o_interrupt=0, o_rx_ready=1, o_tx_valid=0, o_input_port=0, o_tx_data=0, o_rx_count=0, o_tx_overflow=0; prev_port=0.
- o_interrupt is decoded from the registered FSM state, so it is glitch-free.
- Word accepted at edge k, with RX previously empty and FSM in IDLE:
  - o_input_port valid from edge k.
  - FSM enters ANNOUNCE at edge k+1.
  - o_interrupt is high for exactly the cycle between edges k+1 and k+2.
- Output-port change visible before edge k:
  - Data event: TX push at edge k; o_tx_valid high after edge k.
  - Ack event: RX pop at edge k; the next head appears on o_input_port immediately after edge k.
- Reset asserted mid-operation discards all FIFO contents and any pending announcement. No interrupt is emitted after reset releases until a new RX push.

## Structure
- Package io_ctrl_pkg holds:
  - irq_state_t enum {IDLE, ANNOUNCE, WAIT_ACK}
  - ACK_TAG_DEFAULT
  - PORT_W = 16
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count/head), instantiated once for RX and once for TX.
- Edge detector, ack decode and FSM live in the top module.

## Test plan
- Reset, then push 16'h1234 → o_input_port=16'h1234 the next cycle; o_interrupt high exactly one cycle, one cycle after the push; no second pulse without an ack.
- Push 16'hAAAA and 16'hBBBB, wait for the pulse, CPU port writes 16'hF000 → head becomes 16'hBBBB; second pulse one cycle later; write 16'hF001 → RX empty, o_input_port=0.
- Ack 16'hF000 written in IDLE with RX empty, then push 16'h0001 → no pop; one interrupt announces 16'h0001.
- CPU port sequence 0x0005, 0x0005, 0x0006 with i_tx_ready=0 → TX holds exactly 0x0005, 0x0006 (repeated write gives no event).
- DEPTH=4: five data writes with i_tx_ready=0 → o_tx_overflow=1, TX holds the first four in order. Repeat with the fifth write coinciding with i_tx_ready=1 → no overflow.
- Fill RX to 4 → o_rx_ready=0, o_rx_count=4. Assert i_reset mid-WAIT_ACK → all outputs at reset values; no interrupt after release.
